// File: rtl/fip_32_dot3_if.sv
// Operand/result handshake bundle for the Q16.16 3-vector dot-product unit.
interface fip_32_dot3_if;
  logic [31:0] ax;
  logic [31:0] ay;
  logic [31:0] az;
  logic [31:0] bx;
  logic [31:0] by;
  logic [31:0] bz;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dot;
  logic        overflow;
  logic        out_valid;
  logic        out_ready;
  logic        ovf_sticky;
  logic        ovf_clear;

  modport master (
    output ax, ay, az, bx, by, bz, in_valid, out_ready, ovf_clear,
    input  in_ready, dot, overflow, out_valid, ovf_sticky
  );

  modport slave (
    input  ax, ay, az, bx, by, bz, in_valid, out_ready, ovf_clear,
    output in_ready, dot, overflow, out_valid, ovf_sticky
  );
endinterface

// File: rtl/fip_32_dot3.sv
// Three-stage pipelined signed Q16.16 dot product with saturation and sticky overflow.
module fip_32_dot3 #(
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic         clk,
  input  logic         reset,
  fip_32_dot3_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned SW = 66;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic                 advance;
  logic                 v1;
  logic                 v2;
  logic signed [PW-1:0] px;
  logic signed [PW-1:0] py;
  logic signed [PW-1:0] pz;
  logic signed [SW-1:0] sum2;
  logic signed [SW-1:0] shifted;
  logic [DW-1:0]        dot_c;
  logic                 ovf_c;

  // Whole pipeline freezes when the held result is not taken.
  assign advance     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (advance) begin
      v1 <= bus.in_valid;
      v2 <= v1;
    end
  end

  // S1: full-precision products.
  always_ff @(posedge clk) begin
    if (advance && bus.in_valid) begin
      px <= PW'($signed(bus.ax)) * PW'($signed(bus.bx));
      py <= PW'($signed(bus.ay)) * PW'($signed(bus.by));
      pz <= PW'($signed(bus.az)) * PW'($signed(bus.bz));
    end
  end

  // S2: exact sum before any rounding.
  always_ff @(posedge clk) begin
    if (advance && v1) begin
      sum2 <= SW'(px) + SW'(py) + SW'(pz);
    end
  end

  // Floor shift then clamp to the 32-bit range.
  always_comb begin
    shifted = sum2 >>> FRAC_BITS;
    dot_c   = shifted[DW-1:0];
    ovf_c   = 1'b0;
    if (shifted > SAT_MAX) begin
      dot_c = {1'b0, {(DW-1){1'b1}}};
      ovf_c = 1'b1;
    end else if (shifted < SAT_MIN) begin
      dot_c = {1'b1, {(DW-1){1'b0}}};
      ovf_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.dot       <= '0;
      bus.overflow  <= 1'b0;
    end else if (advance) begin
      bus.out_valid <= v2;
      if (v2) begin
        bus.dot      <= dot_c;
        bus.overflow <= ovf_c;
      end
    end
  end

  // Setting by a delivered overflow takes priority over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ovf_sticky <= 1'b0;
    end else if (bus.out_valid && bus.out_ready && bus.overflow) begin
      bus.ovf_sticky <= 1'b1;
    end else if (bus.ovf_clear) begin
      bus.ovf_sticky <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fip_32_dot3.sv
// Directed self-checking bench for fip_32_dot3.
module tb_fip_32_dot3;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  fip_32_dot3_if bus ();

  fip_32_dot3 #(.FRAC_BITS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ax, ay, az, bx, by, bz);
    bus.ax = ax; bus.ay = ay; bus.az = az;
    bus.bx = bx; bus.by = by; bus.bz = bz;
    bus.in_valid = 1'b1;
  endtask

  // Called at a negedge with an empty pipeline; returns at the negedge the result shows.
  task automatic run_one(input string tag, input logic [31:0] ax, ay, az, bx, by, bz,
                         input logic [31:0] exp_dot, input logic exp_ovf);
    drive(ax, ay, az, bx, by, bz);
    chkb({tag, "_in_ready"}, bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chkb({tag, "_lat1"}, bus.out_valid, 1'b0);
    @(negedge clk);
    chkb({tag, "_lat2"}, bus.out_valid, 1'b0);
    @(negedge clk);
    chkb({tag, "_valid"}, bus.out_valid, 1'b1);
    chk({tag, "_dot"}, bus.dot, exp_dot);
    chkb({tag, "_ovf"}, bus.overflow, exp_ovf);
  endtask

  function automatic logic [31:0] bp_exp(input int k);
    return 32'((k - 1) * 65536);
  endfunction

  task automatic drive_bp(input int k);
    drive(32'((k + 1) * 65536), 32'hFFFF_0000, 32'h0, 32'h0001_0000, 32'h0002_0000, 32'h0);
  endtask

  initial begin
    int  tx;
    int  rx;
    int  hold_left;
    bit  hold_started;
    bit  released;
    bit  take;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.ax = '0; bus.ay = '0; bus.az = '0;
    bus.bx = '0; bus.by = '0; bus.bz = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.ovf_clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    chkb("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_dot", bus.dot, 32'h0);
    chkb("rst_ovf", bus.overflow, 1'b0);
    chkb("rst_sticky", bus.ovf_sticky, 1'b0);
    chkb("rst_in_ready", bus.in_ready, 1'b1);

    run_one("basic", 32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
            32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 32'h0020_0000, 1'b0);
    @(negedge clk);
    chkb("basic_bubble", bus.out_valid, 1'b0);

    run_one("floor", 32'h0000_0001, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    run_one("fullsum", 32'h0000_8000, 32'h0000_8000, 32'h0, 32'h0000_0001, 32'h0000_0001, 32'h0,
            32'h0000_0001, 1'b0);
    @(negedge clk);
    chkb("sticky_before", bus.ovf_sticky, 1'b0);

    run_one("satpos", 32'h7530_0000, 32'h7530_0000, 32'h0, 32'h7530_0000, 32'h0, 32'h0,
            32'h7FFF_FFFF, 1'b1);
    @(negedge clk);
    chkb("satpos_sticky", bus.ovf_sticky, 1'b1);

    run_one("satneg", 32'h8AD0_0000, 32'h8AD0_0000, 32'h0, 32'h7530_0000, 32'h0, 32'h0,
            32'h8000_0000, 1'b1);
    bus.ovf_clear = 1'b1;
    @(negedge clk);
    bus.ovf_clear = 1'b0;
    chkb("set_wins_sticky", bus.ovf_sticky, 1'b1);

    // Back-pressure: 5 back-to-back vectors, 4-cycle hold on the first result.
    tx = 0; rx = 0; hold_left = 0; hold_started = 1'b0; released = 1'b0;
    drive_bp(0);
    for (int c = 0; c < 40 && rx < 5; c++) begin
      if (bus.out_valid && !hold_started) begin
        hold_started = 1'b1;
        hold_left    = 4;
      end
      bus.out_ready = (hold_left == 0);
      #1;
      if (hold_left > 0) begin
        chkb("bp_in_ready_hold", bus.in_ready, 1'b0);
        chk("bp_hold_dot", bus.dot, bp_exp(0));
        hold_left--;
        if (hold_left == 0) released = 1'b1;
      end else if (bus.out_valid) begin
        chk("bp_dot", bus.dot, bp_exp(rx));
        chkb("bp_ovf", bus.overflow, 1'b0);
        rx++;
      end else if (released) begin
        chkb("bp_rate", bus.out_valid, 1'b1);
      end
      take = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (take) tx++;
      if (tx < 5) drive_bp(tx);
      else bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    chk("bp_count", 32'(rx), 32'd5);
    chk("bp_sent", 32'(tx), 32'd5);
    @(negedge clk);
    chkb("bp_no_dup", bus.out_valid, 1'b0);
    chkb("sticky_pre_reset", bus.ovf_sticky, 1'b1);

    // Reset with two vectors in flight.
    drive(32'h7530_0000, 32'h0, 32'h0, 32'h7530_0000, 32'h0, 32'h0);
    @(negedge clk);
    drive(32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chkb("rst_mid_valid", bus.out_valid, 1'b0);
      chk("rst_mid_dot", bus.dot, 32'h0);
      chkb("rst_mid_sticky", bus.ovf_sticky, 1'b0);
      @(negedge clk);
    end

    run_one("post_rst", 32'h0001_0000, 32'h0002_0000, 32'h0003_0000,
            32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 32'h0020_0000, 1'b0);
    @(negedge clk);

    run_one("satpos2", 32'h7530_0000, 32'h7530_0000, 32'h0, 32'h7530_0000, 32'h0, 32'h0,
            32'h7FFF_FFFF, 1'b1);
    @(negedge clk);
    chkb("satpos2_sticky", bus.ovf_sticky, 1'b1);
    bus.ovf_clear = 1'b1;
    @(negedge clk);
    bus.ovf_clear = 1'b0;
    chkb("clear_sticky", bus.ovf_sticky, 1'b0);
    @(negedge clk);
    chkb("clear_hold", bus.ovf_sticky, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fip_32_dot3.md
# fip_32_dot3

Pipelined Q16.16 signed 3-vector dot-product unit. It is the consumer stage for the fixed-point multiply/add primitives and is used by the ray–triangle and shading datapaths for N·D, N·L and edge-test products. It accepts one operand pair per cycle on a valid/ready handshake and returns a saturated Q16.16 scalar three cycles later. Per-result and sticky overflow flags are provided.

## Interface
Parameters:
- `FRAC_BITS`, 16: fractional bits of the Q format. The integer part is `32-FRAC_BITS`.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `ax`, `ay`, `az`  in  32 each  vector A, signed Q16.16.
- `bx`, `by`, `bz`  in  32 each  vector B, signed Q16.16.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  unit accepts operands this cycle.
- `dot`  out  32  signed Q16.16 result, saturated.
- `overflow`  out  1  `dot` was clamped. Qualified by `out_valid`.
- `out_valid`  out  1  `dot`/`overflow` valid.
- `out_ready`  in  1  consumer accepts the result.
- `ovf_sticky`  out  1  set by any delivered overflowed result; held until cleared.
- `ovf_clear`  in  1  clears `ovf_sticky`.

## Operation
- Three register stages, S1→S2→S3. Each stage has its own valid bit. S3 drives the outputs.
- S1 computes three full-precision signed 64-bit products: ax·bx, ay·by, az·bz. No truncation happens at this stage.
- S2 sign-extends each product to 66 bits and forms their exact 66-bit sum.
- S3 arithmetically shifts the sum right by `FRAC_BITS`, which truncates toward −∞, the same rounding as the multiply primitive.
  - If the shifted value is > 0x7FFF_FFFF: `dot`=0x7FFF_FFFF, `overflow`=1.
  - If it is < −2^31: `dot`=0x8000_0000, `overflow`=1.
  - Otherwise: `dot` = low 32 bits, `overflow`=0.
- Because the three products are summed before the shift, the result differs from summing three individually truncated products. The full-precision sum is required.
- Intermediate overflow is impossible by width, so the only overflow source is the final saturation.
- Stall handling:
  - `advance = !out_valid || out_ready`.
  - When `advance`=0, all three stages hold their data and valid bits.
  - `in_ready = advance`.
  - Bubbles are not squeezed out.
- An input transfer occurs on `in_valid && in_ready`. An output transfer occurs on `out_valid && out_ready`.
- `ovf_sticky` update rules:
  - Set on an output transfer with `overflow`=1.
  - Cleared when `ovf_clear`=1.
  - If set and clear occur in the same cycle, set wins.

## Timing
- Latency: operands accepted at edge N appear with `out_valid`=1 after edge N+3, given no stall.
- Throughput: 1 result/cycle with `out_ready` held high.
- Reset, at the edge where `reset`=1:
  - All valid bits and `out_valid` = 0.
  - `dot` = 0, `overflow` = 0, `ovf_sticky` = 0.
  - `in_ready` = 1 in the cycle after reset.
  - Data registers other than the outputs need not be reset.
- Reset mid-operation: all in-flight results are discarded, none is ever presented, and `ovf_sticky` is cleared.
- Output stability: while `out_valid`=1 and `out_ready`=0, `dot` and `overflow` hold stable and the unit accepts no input.
- `in_ready` depends combinationally on `out_ready`. The consumer must not make `out_ready` depend on `in_ready`.
- Inputs are sampled only on a transfer. Operand values while `in_valid`=0 are ignored.
- `ovf_sticky` changes one cycle after the setting transfer or clear.

## Test plan
- Basic, single transfer: A=(1.0,2.0,3.0) = 0x0001_0000/0x0002_0000/0x0003_0000, B=(4.0,5.0,6.0).
  - Expect `dot`=0x0020_0000 (32.0), `overflow`=0, exactly 3 cycles after acceptance.
- Floor rounding and full-precision sum:
  - A=(0x0000_0001,0,0), B=(0xFFFF_FFFF,0,0): expect `dot`=0xFFFF_FFFF, `overflow`=0.
  - A=(0x0000_8000,0x0000_8000,0), B=(0x0000_0001,0x0000_0001,0): expect `dot`=0x0000_0001. Per-product truncation would give 0.
- Saturation and sticky flag:
  - A=(30000.0,30000.0,0) = 0x7530_0000 each, B=(30000.0,0,0): expect `dot`=0x7FFF_FFFF, `overflow`=1, then `ovf_sticky`=1.
  - Negated A: expect `dot`=0x8000_0000, `overflow`=1.
  - Pulse `ovf_clear` in the same cycle as a transfer with `overflow`=1: `ovf_sticky` stays 1.
  - Pulse `ovf_clear` alone: `ovf_sticky`=0 next cycle.
- Back-pressure: stream 5 distinct vectors back-to-back and hold `out_ready`=0 for 4 cycles starting when the first result appears.
  - `in_ready`=0 during the hold.
  - The first `dot` is stable during the hold.
  - All 5 results are delivered in order with no loss or duplication.
  - Afterwards, 1 result/cycle.
- Reset mid-flight: accept 2 vectors, assert `reset` one cycle later.
  - `out_valid` stays 0 for ≥3 cycles afterwards.
  - `dot`=0 and `ovf_sticky`=0.
  - A vector sent after reset returns correctly with 3-cycle latency.
